drysponge_mix_seq: RTL and testbench

Sequential mix-phase engine for the DrySponge/DryGASCON core. It accepts one input block plus its domain-separator bits and walks the concatenated bit stream in chunks of `CW*IW` bits. For each chunk it presents `c_in` XOR-mixed with x-words selected by `IW`-bit indices. After each mix it waits for the external permutation round to finish before the next chunk. It generalises the single-step combinational mix to arbitrary `XW32` (power of two), block width and domain width, and adds step sequencing and a handshake.

---
 rtl/drysponge_mix_seq.sv | 164 ++++++++++++++++
 tb/tb_drysponge_mix_seq.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drysponge_mix_seq.sv
// drysponge_mix_seq: sequential DrySponge/DryGASCON mix-phase engine.
// Walks the latched {pad, ds, data} stream in CW*IW-bit chunks. Each chunk
// selects one x word per capacity word, and that x word is XORed into the
// upper half of the capacity word. Between chunks the engine waits for the
// external permutation round to report completion.
// Optional feature: define DRYSPONGE_MIX_SEQ_ABORT_EN to add an `abort` input.
// The abort input returns the engine to idle from any state.
module drysponge_mix_seq #(
    parameter int CW   = 5,
    parameter int XW32 = 4,
    parameter int DW   = 128,
    parameter int DSW  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    input  logic [DSW-1:0]       in_ds,
    input  logic [64*CW-1:0]     c_in,
    input  logic [32*XW32-1:0]   x,
    output logic [64*CW-1:0]     c_out,
    output logic                 c_valid,
    output logic                 c_last,
    input  logic                 perm_done,
`ifdef DRYSPONGE_MIX_SEQ_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 busy,
    output logic                 done
);

    localparam int IW    = $clog2(XW32);
    localparam int CHK   = CW * IW;
    localparam int STEPS = (DW + DSW + CHK - 1) / CHK;
    localparam int SW    = STEPS * CHK;
    localparam int STW   = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STW-1:0] LAST_STEP = STW'(STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MIX  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t          state_q;
    logic [STW-1:0]  step_q;
    logic [SW-1:0]   s_q;
    logic            in_ready_q;
    logic            c_valid_q;
    logic            c_last_q;
    logic            busy_q;
    logic            done_q;

    // Control FSM; every handshake output is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            s_q        <= '0;
            in_ready_q <= 1'b1;
            c_valid_q  <= 1'b0;
            c_last_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end
`ifdef DRYSPONGE_MIX_SEQ_ABORT_EN
        else if (abort) begin
            // Abort leaves the latched stream alone; only sequencing is dropped.
            state_q    <= ST_IDLE;
            step_q     <= '0;
            in_ready_q <= 1'b1;
            c_valid_q  <= 1'b0;
            c_last_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end
`endif
        else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        s_q        <= SW'({in_ds, in_data});
                        step_q     <= '0;
                        state_q    <= ST_MIX;
                        c_valid_q  <= 1'b1;
                        c_last_q   <= (LAST_STEP == '0);
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                    end
                end
                ST_MIX: begin
                    state_q   <= ST_WAIT;
                    c_valid_q <= 1'b0;
                    c_last_q  <= 1'b0;
                end
                ST_WAIT: begin
                    if (perm_done) begin
                        if (step_q == LAST_STEP) begin
                            state_q    <= ST_IDLE;
                            done_q     <= 1'b1;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            step_q    <= step_q + 1'b1;
                            state_q   <= ST_MIX;
                            c_valid_q <= 1'b1;
                            c_last_q  <= ((step_q + 1'b1) == LAST_STEP);
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    step_q     <= '0;
                    in_ready_q <= 1'b1;
                    c_valid_q  <= 1'b0;
                    c_last_q   <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign c_valid  = c_valid_q;
    assign c_last   = c_last_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // Chunk table: one CHK-bit slice of the stream per step, chosen by step_q.
    logic [CHK-1:0] chunk_tab [STEPS];
    logic [CHK-1:0] chunk;

    genvar gi;
    generate
        for (gi = 0; gi < STEPS; gi++) begin : g_chunk
            assign chunk_tab[gi] = s_q[gi*CHK +: CHK];
        end
    endgenerate

    assign chunk = chunk_tab[step_q];

    // x word table; word 0 sits in the most significant slot of x.
    logic [31:0] xx_w [XW32];

    generate
        for (gi = 0; gi < XW32; gi++) begin : g_xx
            assign xx_w[gi] = x[32*XW32-32*(gi+1) +: 32];
        end
    endgenerate

    // Per-word mix: only the upper 32 bits of each capacity word change.
    logic [IW-1:0] idx_w [CW];

    generate
        for (gi = 0; gi < CW; gi++) begin : g_mix
            assign idx_w[gi] = chunk[IW*gi +: IW];
            assign c_out[64*CW-64*(gi+1) +: 64] =
                c_in[64*CW-64*(gi+1) +: 64] ^ {xx_w[idx_w[gi]], 32'b0};
        end
    endgenerate

endmodule

// File: tb/tb_drysponge_mix_seq.sv
// Scoreboard bench for drysponge_mix_seq: the expected XOR pattern of every
// step is queued when a block is accepted and popped on each c_valid strobe.
module tb_drysponge_mix_seq;

    localparam int CW    = 5;
    localparam int XW32  = 4;
    localparam int DW    = 128;
    localparam int DSW   = 4;
    localparam int IW    = 2;
    localparam int CHK   = CW * IW;
    localparam int STEPS = 14;
    localparam int SW    = STEPS * CHK;
    localparam int CWB   = 64 * CW;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic [DSW-1:0]    in_ds;
    logic [CWB-1:0]    c_in;
    logic [32*XW32-1:0] x;
    logic [CWB-1:0]    c_out;
    logic              c_valid;
    logic              c_last;
    logic              perm_done;
    logic              busy;
    logic              done;
`ifdef DRYSPONGE_MIX_SEQ_ABORT_EN
    logic              abort;
`endif

    always #5 clk = ~clk;

    drysponge_mix_seq #(.CW(CW), .XW32(XW32), .DW(DW), .DSW(DSW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ds     (in_ds),
        .c_in      (c_in),
        .x         (x),
        .c_out     (c_out),
        .c_valid   (c_valid),
        .c_last    (c_last),
        .perm_done (perm_done),
`ifdef DRYSPONGE_MIX_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [CWB-1:0] mask;
        logic           last;
    } exp_t;

    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          cv_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] xx_tab [4];
    int          probe_step [2];
    int          probe_word [2];
    logic [31:0] probe_val  [2];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (c_valid) cv_cnt <= cv_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [CWB-1:0] obs,
                             input logic [CWB-1:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [SW-1:0] mk_stream(input logic [DW-1:0] d,
                                                input logic [DSW-1:0] ds);
        logic [SW-1:0] s;
        s = '0;
        for (int b = 0; b < DW; b++) s[b] = d[b];
        for (int b = 0; b < DSW; b++) s[DW+b] = ds[b];
        return s;
    endfunction

    // Reference: bit-by-bit index extraction and placement of the chosen x word.
    function automatic logic [CWB-1:0] model_mask(input logic [SW-1:0] s, input int k);
        logic [CWB-1:0] m;
        int idx;
        m = '0;
        for (int i = 0; i < CW; i++) begin
            idx = 0;
            for (int t = 0; t < IW; t++)
                if (s[k*CHK + IW*i + t]) idx += (1 << t);
            for (int b = 0; b < 32; b++)
                m[CWB - 64*(i+1) + 32 + b] = xx_tab[idx][b];
        end
        return m;
    endfunction

    function automatic logic [63:0] get_word(input logic [CWB-1:0] v, input int w);
        return v[CWB - 64*(w+1) +: 64];
    endfunction

    task automatic rand_cin();
        for (int w = 0; w < CWB/32; w++) c_in[32*w +: 32] = $urandom();
    endtask

    // Offer a block when the engine is ready and queue its expected steps.
    task automatic accept_block(input logic [DW-1:0] d, input logic [DSW-1:0] ds,
                                output int t_acc);
        logic [SW-1:0] s;
        int w;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check_val("ready_wait", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_ds    = ds;
        s = mk_stream(d, ds);
        for (int k = 0; k < STEPS; k++)
            sb.push_back('{mask: model_mask(s, k), last: (k == STEPS-1)});
        t_acc = cyc;
        $display("accept data=%h ds=%h at cycle %0d", d, ds, t_acc);
    endtask

    // Serve n_steps mix strobes; perm_done arrives d cycles after each MIX.
    task automatic run_steps(input int t_acc, input int d, input bit hold,
                             input int n_steps, input bit stop);
        int prev;
        int w;
        exp_t e;
        logic [CWB-1:0] diff;
        prev = t_acc;
        @(negedge clk);
        in_valid = 1'b0;
        for (int s = 0; s < n_steps; s++) begin
            w = 0;
            while (!c_valid && w < 200) begin
                @(negedge clk);
                w++;
            end
            check_val("cvalid_wait", c_valid, 1);
            if (!c_valid) return;
            check_val("spacing", cyc - prev, (s == 0) ? 1 : d + 1);
            prev = cyc;
            diff = c_out ^ c_in;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_val("mix", diff, e.mask);
                check_val("last", c_last, e.last);
            end else begin
                check_val("sb_underflow", sb.size(), 1);
            end
            for (int p = 0; p < 2; p++)
                if (probe_step[p] == s)
                    check_val("probe", get_word(diff, probe_word[p]), {probe_val[p], 32'b0});
            $display("step %0d c_valid cycle %0d last=%b", s, cyc, c_last);
            rand_cin();
            perm_done = hold;
            for (int j = 1; j < d; j++) begin
                @(negedge clk);
                perm_done = 1'b0;
            end
            if (stop && s == n_steps - 1) begin
                @(negedge clk);
                return;
            end
            @(negedge clk);
            perm_done = 1'b1;
            @(negedge clk);
        end
        check_val("done", done, 1);
        check_val("done_ready", in_ready, 1);
        check_val("done_busy", busy, 0);
        check_val("done_cycle", cyc - t_acc, STEPS*(d+1) + 1);
        if (!hold) perm_done = 1'b0;
    endtask

    task automatic full_block(input logic [DW-1:0] d, input logic [DSW-1:0] ds,
                              input int dl, input bit hold, input string tag);
        int t_acc;
        int cv0;
        int dn0;
        #1;
        cv0 = cv_cnt;
        dn0 = done_cnt;
        accept_block(d, ds, t_acc);
        run_steps(t_acc, dl, hold, STEPS, 1'b0);
        @(negedge clk);
        #1;
        check_val({tag, "_cv_count"}, cv_cnt - cv0, STEPS);
        check_val({tag, "_done_count"}, done_cnt - dn0, 1);
        $display("block %s complete", tag);
    endtask

    task automatic clear_probes();
        for (int p = 0; p < 2; p++) probe_step[p] = -1;
    endtask

    initial begin
        int t_acc;
        int cv0;
        int dn0;
        xx_tab[0] = 32'hA0A0A0A0;
        xx_tab[1] = 32'hB1B1B1B1;
        xx_tab[2] = 32'hC2C2C2C2;
        xx_tab[3] = 32'hD3D3D3D3;
        x = {xx_tab[0], xx_tab[1], xx_tab[2], xx_tab[3]};
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_ds = '0;
        perm_done = 1'b0;
`ifdef DRYSPONGE_MIX_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        clear_probes();
        rand_cin();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check_val("rst_ready", in_ready, 1);
        check_val("rst_cvalid", c_valid, 0);
        check_val("rst_clast", c_last, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_cout", c_out ^ c_in, model_mask('0, 0));

        // All-zero block: every word picks xx[0]
        full_block('0, '0, 1, 1'b0, "zero");

        // in_data[1:0]=11: word 0 of step 0 picks xx[3]
        clear_probes();
        probe_step[0] = 0; probe_word[0] = 0; probe_val[0] = 32'hD3D3D3D3;
        probe_step[1] = 0; probe_word[1] = 1; probe_val[1] = 32'hA0A0A0A0;
        full_block(128'h3, '0, 1, 1'b0, "data3");

        // in_ds=F: step 12 word 4 and step 13 word 0 pick xx[3]
        clear_probes();
        probe_step[0] = 12; probe_word[0] = 4; probe_val[0] = 32'hD3D3D3D3;
        probe_step[1] = 13; probe_word[1] = 0; probe_val[1] = 32'hD3D3D3D3;
        full_block('0, 4'hF, 1, 1'b0, "dsF");
        clear_probes();

        // perm_done high in IDLE/MIX, arriving 5 cycles after each MIX in WAIT
        perm_done = 1'b1;
        full_block({$urandom(), $urandom(), $urandom(), $urandom()}, 4'(($urandom())), 5, 1'b1, "slow");
        perm_done = 1'b0;

        // Reset during WAIT of step 7
        accept_block({$urandom(), $urandom(), $urandom(), $urandom()}, 4'h5, t_acc);
        run_steps(t_acc, 1, 1'b0, 8, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst_ready", in_ready, 1);
        check_val("midrst_busy", busy, 0);
        check_val("midrst_cvalid", c_valid, 0);
        check_val("midrst_done", done, 0);
        sb.delete();
        #1;
        cv0 = cv_cnt;
        dn0 = done_cnt;
        repeat (10) @(negedge clk);
        #1;
        check_val("midrst_no_cv", cv_cnt - cv0, 0);
        check_val("midrst_no_done", done_cnt - dn0, 0);
        full_block({$urandom(), $urandom(), $urandom(), $urandom()}, 4'hA, 1, 1'b0, "after_rst");

`ifdef DRYSPONGE_MIX_SEQ_ABORT_EN
        // Abort together with perm_done in WAIT of step 3
        accept_block({$urandom(), $urandom(), $urandom(), $urandom()}, 4'h3, t_acc);
        run_steps(t_acc, 1, 1'b0, 4, 1'b1);
        abort = 1'b1;
        perm_done = 1'b1;
        #1;
        cv0 = cv_cnt;
        dn0 = done_cnt;
        @(negedge clk);
        abort = 1'b0;
        perm_done = 1'b0;
        check_val("abort_ready", in_ready, 1);
        check_val("abort_busy", busy, 0);
        check_val("abort_cvalid", c_valid, 0);
        sb.delete();
        repeat (10) @(negedge clk);
        #1;
        check_val("abort_no_cv", cv_cnt - cv0, 0);
        check_val("abort_no_done", done_cnt - dn0, 0);
        // Abort together with in_valid in IDLE: block refused
        @(negedge clk);
        abort = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        in_valid = 1'b0;
        check_val("abort_accept_busy", busy, 0);
        check_val("abort_accept_cvalid", c_valid, 0);
        check_val("abort_accept_ready", in_ready, 1);
        full_block('0, '0, 1, 1'b0, "after_abort");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
